// File: rtl/dpram_rd_streamer_pkg.sv
// Shared defaults and FSM encoding for the dual-port RAM read streamer.
package dpram_rd_streamer_pkg;

  localparam int DEF_AW        = 3;
  localparam int DEF_DW        = 16;
  localparam int DEF_BUF_DEPTH = 4;
  localparam int MAX_LEN       = 2 ** DEF_AW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/dpram_rd_streamer_fifo.sv
// Single-clock output buffer: DEPTH entries of data plus a last flag.
module sync_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty
);

  logic [DW:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [DW:0]   head;
  logic          do_push;
  logic          do_pop;

  assign full    = (occupancy == CW'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is masked while empty so the stream outputs read zero after reset.
  assign head    = mem[rptr];
  assign rd_data = empty ? '0 : head[DW-1:0];
  assign rd_last = empty ? 1'b0 : head[DW];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      occupancy <= occupancy + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dpram_rd_streamer.sv
// Burst read sequencer on the RAM read port, streaming words out via valid/ready.
//
// state     | meaning
// ST_IDLE   | waiting for start; first read is launched on acceptance
// ST_ISSUE  | one re per word while the buffer has room
// ST_DRAIN  | all reads issued; waiting for the last word to be accepted
// ST_FINISH | one cycle; done pulses and busy drops on exit
module dpram_rd_streamer
  import dpram_rd_streamer_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          re,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int LW      = AW + 1;
  localparam int LEN_MAX = 2 ** AW;
  localparam int PW      = $clog2(BUF_DEPTH);
  localparam int SW      = PW + 2;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_c;
  logic [LW-1:0] issued;
  logic [LW-1:0] accepted;
  logic [AW-1:0] next_addr;
  logic          re_last;
  logic          pend;
  logic          pend_last;
  logic [PW:0]   occ;
  logic          buf_full;
  logic          buf_empty;
  logic          buf_push;
  logic          pop;
  logic [SW-1:0] load;
  logic          can_issue;

  assign m_valid  = !buf_empty;
  assign pop      = m_valid && m_ready;
  assign buf_push = pend && (!buf_full || pop);

  // Credit check counts words already buffered plus reads still in flight.
  always_comb begin
    len_c     = (len > LW'(LEN_MAX)) ? LW'(LEN_MAX) : len;
    load      = SW'(occ) + SW'(re) + SW'(pend) - SW'(pop);
    can_issue = (load < SW'(BUF_DEPTH));
  end

  sync_fifo_buf #(
    .DEPTH (BUF_DEPTH),
    .DW    (DW)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (rd_data),
    .push_last (pend_last),
    .pop       (pop),
    .rd_data   (m_data),
    .rd_last   (m_last),
    .occupancy (occ),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      re        <= 1'b0;
      rd_addr   <= '0;
      next_addr <= '0;
      len_q     <= '0;
      issued    <= '0;
      accepted  <= '0;
      re_last   <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      // rd_data for a read launched last cycle is valid now.
      pend      <= re;
      pend_last <= re && re_last;
      done      <= 1'b0;
      if (pop) accepted <= accepted + LW'(1);

      case (state)
        ST_IDLE: begin
          re      <= 1'b0;
          re_last <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            len_q    <= len_c;
            accepted <= '0;
            if (len_c == '0) begin
              issued <= '0;
              state  <= ST_FINISH;
            end else begin
              re        <= 1'b1;
              rd_addr   <= start_addr;
              next_addr <= start_addr + AW'(1);
              issued    <= LW'(1);
              re_last   <= (len_c == LW'(1));
              state     <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (issued == len_q) begin
            re      <= 1'b0;
            re_last <= 1'b0;
            state   <= ST_DRAIN;
          end else if (can_issue) begin
            re        <= 1'b1;
            rd_addr   <= next_addr;
            next_addr <= next_addr + AW'(1);
            issued    <= issued + LW'(1);
            re_last   <= (issued + LW'(1) == len_q);
          end else begin
            re      <= 1'b0;
            re_last <= 1'b0;
          end
        end

        ST_DRAIN: begin
          re <= 1'b0;
          if (pop && (accepted + LW'(1) == len_q)) state <= ST_FINISH;
        end

        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_rd_streamer.sv
// Directed bench for dpram_rd_streamer with a behavioural 8x16 dual-port RAM.
module tb_dpram_rd_streamer;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          re;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] ram [8];
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  // RAM with both ports on clk; registered read output
  always @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    if (re) rd_data <= ram[rd_addr];
  end

  dpram_rd_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .re         (re),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_data [$];
  logic          q_last [$];
  int            q_cyc  [$];
  logic [AW-1:0] q_addr [$];
  int            re_before_pop;
  int            done_cnt;
  int            done_cyc;
  int            valid_cnt;
  int            stall_bad;
  logic          busy0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [AW-1:0] a, input logic [AW:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    tick();
    start = 1'b0;
  endtask

  // Cycle c of the loop is the cycle after edge c, where edge 0 accepted start.
  task automatic collect(input int ncyc, input int stall, input int inj);
    logic [DW-1:0] held;
    bit            holding;
    holding = 1'b0;
    held    = '0;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    q_addr.delete();
    re_before_pop = 0;
    done_cnt      = 0;
    done_cyc      = -1;
    valid_cnt     = 0;
    stall_bad     = 0;
    for (int c = 0; c < ncyc; c++) begin
      m_ready = (c >= stall);
      if (c == inj) begin
        start      = 1'b1;
        start_addr = 3'd4;
        len        = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (c == 0) busy0 = busy;
      if (re) begin
        q_addr.push_back(rd_addr);
        if (q_data.size() == 0) re_before_pop++;
      end
      if (m_valid) valid_cnt++;
      if (m_valid && !m_ready) begin
        if (holding && (m_data !== held)) stall_bad++;
        held    = m_data;
        holding = 1'b1;
      end
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_cyc.push_back(c);
        holding = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    m_ready    = 1'b1;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;

    for (int i = 0; i < 8; i++) begin
      we    = 1'b1;
      waddr = AW'(i);
      wdata = 16'h00A0 + 16'(i);
      tick();
    end
    we = 1'b0;
    tick();

    check("reset busy",    busy,    0);
    check("reset done",    done,    0);
    check("reset re",      re,      0);
    check("reset rd_addr", rd_addr, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data",  m_data,  0);
    check("reset m_last",  m_last,  0);
    rst = 1'b0;
    tick();

    // 1: basic burst
    issue_start(3'd2, 4'd3);
    collect(12, 0, -1);
    check("t1 busy at start", busy0, 1);
    check("t1 words", q_data.size(), 3);
    check("t1 d0", q_data[0], 16'h00A2);
    check("t1 d1", q_data[1], 16'h00A3);
    check("t1 d2", q_data[2], 16'h00A4);
    check("t1 c0", q_cyc[0], 2);
    check("t1 c1", q_cyc[1], 3);
    check("t1 c2", q_cyc[2], 4);
    check("t1 l0", q_last[0], 0);
    check("t1 l1", q_last[1], 0);
    check("t1 l2", q_last[2], 1);
    check("t1 done count", done_cnt, 1);
    check("t1 done cycle", done_cyc, 6);
    check("t1 busy end", busy, 0);

    // 2: wrap-around
    issue_start(3'd6, 4'd4);
    collect(12, 0, -1);
    check("t2 re count", q_addr.size(), 4);
    check("t2 a0", q_addr[0], 6);
    check("t2 a1", q_addr[1], 7);
    check("t2 a2", q_addr[2], 0);
    check("t2 a3", q_addr[3], 1);
    check("t2 words", q_data.size(), 4);
    check("t2 d0", q_data[0], 16'h00A6);
    check("t2 d1", q_data[1], 16'h00A7);
    check("t2 d2", q_data[2], 16'h00A0);
    check("t2 d3", q_data[3], 16'h00A1);
    check("t2 done count", done_cnt, 1);

    // 3: back-pressure for 10 cycles
    issue_start(3'd0, 4'd8);
    collect(30, 10, -1);
    check("t3 re before pop <= 4", (re_before_pop <= 4), 1);
    check("t3 re count", q_addr.size(), 8);
    check("t3 stall stable", stall_bad, 0);
    check("t3 first pop cycle", q_cyc[0], 10);
    check("t3 words", q_data.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3 d%0d", k), q_data[k], 16'h00A0 + 16'(k));
      check($sformatf("t3 l%0d", k), q_last[k], (k == 7) ? 1 : 0);
    end
    check("t3 done count", done_cnt, 1);
    check("t3 busy end", busy, 0);

    // 4a: empty burst
    issue_start(3'd5, 4'd0);
    collect(6, 0, -1);
    check("t4a busy at start", busy0, 1);
    check("t4a re count", q_addr.size(), 0);
    check("t4a valid count", valid_cnt, 0);
    check("t4a done count", done_cnt, 1);
    check("t4a done cycle", done_cyc, 1);
    check("t4a busy end", busy, 0);

    // 4b: len 12 clamps to 8
    issue_start(3'd5, 4'd12);
    collect(20, 0, -1);
    check("t4b re count", q_addr.size(), 8);
    check("t4b words", q_data.size(), 8);
    check("t4b d0", q_data[0], 16'h00A5);
    check("t4b d3", q_data[3], 16'h00A0);
    check("t4b d7", q_data[7], 16'h00A4);
    for (int k = 0; k < 8; k++)
      check($sformatf("t4b l%0d", k), q_last[k], (k == 7) ? 1 : 0);
    check("t4b done count", done_cnt, 1);

    // 5: start while busy is ignored
    issue_start(3'd1, 4'd5);
    collect(16, 0, 2);
    check("t5 words", q_data.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("t5 d%0d", k), q_data[k], 16'h00A1 + 16'(k));
    check("t5 l4", q_last[4], 1);
    check("t5 re count", q_addr.size(), 5);
    check("t5 done count", done_cnt, 1);
    check("t5 busy end", busy, 0);

    // 6: reset after two accepted words
    m_ready = 1'b1;
    issue_start(3'd0, 4'd8);
    tick();
    tick();
    check("t6 first word", m_data, 16'h00A0);
    tick();
    check("t6 second word", m_data, 16'h00A1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 rst busy",    busy,    0);
    check("t6 rst done",    done,    0);
    check("t6 rst re",      re,      0);
    check("t6 rst rd_addr", rd_addr, 0);
    check("t6 rst m_valid", m_valid, 0);
    check("t6 rst m_data",  m_data,  0);
    check("t6 rst m_last",  m_last,  0);
    collect(10, 0, -1);
    check("t6 no done", done_cnt, 0);
    check("t6 no valid", valid_cnt, 0);
    check("t6 no re", q_addr.size(), 0);
    issue_start(3'd3, 4'd1);
    collect(10, 0, -1);
    check("t6 words", q_data.size(), 1);
    check("t6 d0", q_data[0], 16'h00A3);
    check("t6 l0", q_last[0], 1);
    check("t6 done cycle", done_cyc, 4);
    check("t6 done count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
